layer_out_serializer: RTL and testbench
=======================================

LAYER_OUT_SERIALIZER -- requirements
Module: layer_out_serializer

Interface
REQ-001 SHALL have parameter numNeuron, default 30, meaning the number of neuron lanes collected per frame.
REQ-002 SHALL have parameter dataWidth, default 16, meaning the width of one neuron activation.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port neuron_out, input, numNeuron*dataWidth; lane i occupies bits [i*dataWidth +: dataWidth].
REQ-006 SHALL have port neuron_valid, input, numNeuron; bit i is a one-cycle pulse qualifying lane i.
REQ-007 SHALL have port out_data, output, dataWidth, the serialized activation (the next layer's myinput).
REQ-008 SHALL have port out_valid, output, 1, qualifying out_data (the next layer's myinputValid).
REQ-009 SHALL have port out_ready, input, 1, downstream acceptance; tie high when feeding a neuron directly.
REQ-010 SHALL have port frame_done, output, 1, a one-cycle pulse after the last word is accepted.
REQ-011 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-012 SHALL have port overrun, output, 1, a sticky flag set when a lane valid arrives during STREAM.

Function
REQ-013 SHALL use three states: IDLE, COLLECT and STREAM.
REQ-014 SHALL, in IDLE or COLLECT, write lane i into buffer entry i and set captured-mask bit i on any cycle where neuron_valid[i]=1.
REQ-015 SHALL move from IDLE to COLLECT on the first cycle where any neuron_valid bit is high.
REQ-016 SHALL, when several lanes are valid in the same cycle, capture all of them in that cycle.
REQ-017 SHALL, on a repeat valid for an already captured lane in COLLECT, overwrite the entry (last wins) and leave the mask unchanged.
REQ-018 SHALL move to STREAM in the cycle after the mask, including that cycle's captures, becomes all ones; the read index is set to 0.
REQ-019 SHALL, if all lanes are valid in one cycle while in IDLE, go to COLLECT and then STREAM on the next cycle.
REQ-020 SHALL, in STREAM, drive out_valid=1 and out_data=buffer[index]; out_data and out_valid are registered outputs.
REQ-021 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL treat a transfer as out_valid and out_ready both high at a rising edge; on a transfer, index increments by 1.
REQ-023 SHALL, on the transfer at index numNeuron-1, clear out_valid and the mask, pulse frame_done for 1 cycle, and return to IDLE.
REQ-024 SHALL give, with out_ready held high, numNeuron back-to-back out_valid cycles; first out_valid 1 cycle after the STREAM entry edge.
REQ-025 SHALL ignore neuron_valid during STREAM (buffer unchanged) and set overrun, which stays set until reset.
REQ-026 SHALL ignore lane valids in the frame_done cycle (the state is already IDLE by then) except for starting a new COLLECT per REQ-015.
REQ-027 SHALL size the index register as $clog2(numNeuron)+1 bits so that it never wraps before the terminal compare.
REQ-028 SHALL perform no arithmetic on data; data passes bit-exact.

Reset
REQ-029 SHALL, on rst low at any time including mid-frame, immediately set: state=IDLE, mask=0, index=0, out_valid=0, out_data=0, frame_done=0, busy=0, overrun=0.
REQ-030 SHALL leave buffer contents unreset (do-not-care); they are never output before recapture.
REQ-031 SHALL start the first capture only after rst is deasserted, on a clean clk edge.

Structure
REQ-032 SHALL place the state encodings (IDLE=0, COLLECT=1, STREAM=2) and the default dataWidth in the shared include header used by the neuron layer.
REQ-033 SHALL be a single module with no sub-module; the buffer is an inferred register array.
REQ-034 SHALL instantiate one block per layer between that layer's neuron outputs and the next layer's neuron inputs.

Verification (numNeuron=4, dataWidth=16)
REQ-035 Single frame: pulse lanes 0..3 on separate cycles with 0x0011, 0x0022, 0x0033, 0x0044, out_ready=1 -> out_data 0x0011, 0x0022, 0x0033, 0x0044 on 4 consecutive out_valid cycles, then one frame_done pulse.
REQ-036 Simultaneous capture: all 4 valid in one cycle with 0xA000..0xA003 -> stream starts 2 cycles later, in order, with busy high throughout.
REQ-037 Backpressure: out_ready=0 for 3 cycles at index 1 -> 0x0022 held stable for 4 cycles, no words lost or duplicated.
REQ-038 Overwrite/overrun: lane 2 pulsed twice (0x0100 then 0x0200) before lane 3 -> streams 0x0200; a lane pulse during STREAM -> overrun=1 and stream data unchanged.
REQ-039 Reset mid-stream: rst low at index 2 -> out_valid=0 and busy=0 asynchronously; a fresh frame afterwards streams correctly from index 0.

Source files
------------

// File: rtl/layer_out_serializer_pkg.sv
// Shared definitions for the layer output serializer: FSM encodings and the
// default activation width used by the neuron layer.
package layer_out_serializer_pkg;

  localparam int DATA_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    STREAM  = 2'd2
  } state_t;

endpackage

// File: rtl/layer_out_serializer_if.sv
// Bus between a layer's parallel neuron outputs and the next layer's serial input.
// The master side is the serializer; the slave side is the surrounding fabric.
interface layer_out_serializer_if
  import layer_out_serializer_pkg::*;
#(
  parameter int numNeuron = 30,
  parameter int dataWidth = DATA_WIDTH_DEFAULT
) ();

  logic [numNeuron*dataWidth-1:0] neuron_out;
  logic [numNeuron-1:0]           neuron_valid;
  logic [dataWidth-1:0]           out_data;
  logic                           out_valid;
  logic                           out_ready;
  logic                           frame_done;
  logic                           busy;
  logic                           overrun;

  modport master (
    input  neuron_out, neuron_valid, out_ready,
    output out_data, out_valid, frame_done, busy, overrun
  );

  modport slave (
    output neuron_out, neuron_valid, out_ready,
    input  out_data, out_valid, frame_done, busy, overrun
  );

endinterface

// File: rtl/layer_out_serializer.sv
// Collects one activation per neuron lane into a frame buffer, then streams the
// frame lane-by-lane over a valid/ready port into the next layer.
//
// state   | meaning
// IDLE    | no lanes captured yet; first valid starts a frame
// COLLECT | capturing lanes until every mask bit is set
// STREAM  | emitting buffer[0..numNeuron-1]; lane valids flag overrun
module layer_out_serializer
  import layer_out_serializer_pkg::*;
#(
  parameter int numNeuron = 30,
  parameter int dataWidth = DATA_WIDTH_DEFAULT
) (
  input logic                    clk,
  input logic                    rst,
  layer_out_serializer_if.master bus
);

  localparam int IW = $clog2(numNeuron) + 1;
  localparam int AW = (numNeuron > 1) ? $clog2(numNeuron) : 1;
  localparam logic [IW-1:0] LAST = IW'(numNeuron - 1);

  state_t               state;
  logic [numNeuron-1:0] mask;
  logic [numNeuron-1:0] mask_nxt;
  logic [IW-1:0]        idx;
  logic [IW-1:0]        idx_inc;
  logic [dataWidth-1:0] buffer [numNeuron];
  logic [dataWidth-1:0] out_data_q;
  logic                 out_valid_q;
  logic                 frame_done_q;
  logic                 busy_q;
  logic                 overrun_q;

  assign mask_nxt = mask | bus.neuron_valid;
  assign idx_inc  = idx + IW'(1);

  // Frame buffer is deliberately unreset; every entry is recaptured before it streams.
  always_ff @(posedge clk) begin
    if (state != STREAM) begin
      for (int i = 0; i < numNeuron; i++) begin
        if (bus.neuron_valid[i]) buffer[i] <= bus.neuron_out[i*dataWidth +: dataWidth];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      mask         <= '0;
      idx          <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.neuron_valid) begin
            mask   <= mask_nxt;
            state  <= COLLECT;
            busy_q <= 1'b1;
          end
        end
        COLLECT: begin
          mask <= mask_nxt;
          if (&mask_nxt) begin
            state <= STREAM;
            idx   <= '0;
          end
        end
        STREAM: begin
          if (|bus.neuron_valid) overrun_q <= 1'b1;
          // First STREAM cycle only loads the output register.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_data_q  <= buffer[idx[AW-1:0]];
          end else if (bus.out_ready) begin
            if (idx == LAST) begin
              out_valid_q  <= 1'b0;
              mask         <= '0;
              idx          <= '0;
              frame_done_q <= 1'b1;
              state        <= IDLE;
              busy_q       <= 1'b0;
            end else begin
              idx        <= idx_inc;
              out_data_q <= buffer[idx_inc[AW-1:0]];
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_layer_out_serializer.sv
// Directed bench for layer_out_serializer with 4 lanes of 16 bits.
module tb_layer_out_serializer;

  localparam int N  = 4;
  localparam int DW = 16;

  logic clk;
  logic rst;

  layer_out_serializer_if #(.numNeuron(N), .dataWidth(DW)) bus ();

  layer_out_serializer #(.numNeuron(N), .dataWidth(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] got [8];
  int got_n, fd_cnt, fd_gap, first_valid_cyc, last_xfer_cyc, busy_low, hold_cnt, hold_bad;

  task automatic pulse(input int lane, input logic [15:0] val);
    @(negedge clk);
    bus.neuron_valid = 4'(1 << lane);
    bus.neuron_out[lane*DW +: DW] = val;
    @(negedge clk);
    bus.neuron_valid = '0;
  endtask

  // Observes the stream at each falling edge, optionally stalling out_ready.
  task automatic stream_capture(input int stall_at, input int stall_len, input int budget);
    int cyc;
    int stall_left;
    logic [15:0] hold_val;
    logic hv;
    got_n = 0; fd_cnt = 0; fd_gap = -1; first_valid_cyc = -1; last_xfer_cyc = -1;
    busy_low = 0; hold_cnt = 0; hold_bad = 0;
    stall_left = stall_len; hv = 1'b0; hold_val = '0; cyc = 0;
    bus.out_ready = 1'b1;
    while (cyc < budget && fd_cnt == 0) begin
      @(negedge clk);
      cyc++;
      bus.neuron_valid = '0;
      if (bus.frame_done) begin
        fd_cnt++;
        fd_gap = cyc - last_xfer_cyc;
      end else begin
        if (!bus.busy) busy_low++;
        if (bus.out_valid) begin
          if (first_valid_cyc < 0) first_valid_cyc = cyc;
          if (got_n == stall_at) begin
            hold_cnt++;
            if (!hv) begin
              hold_val = bus.out_data;
              hv = 1'b1;
            end else if (bus.out_data !== hold_val) hold_bad++;
          end
          if (got_n == stall_at && stall_left > 0) begin
            bus.out_ready = 1'b0;
            stall_left--;
          end else begin
            bus.out_ready = 1'b1;
            if (got_n < 8) got[got_n] = bus.out_data;
            got_n++;
            last_xfer_cyc = cyc;
          end
        end
      end
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.out_data !== 16'h0000) begin bad++; $display("FAIL reset_out_data got=%h want=0000", bus.out_data); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b want=0", bus.frame_done); end
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", bus.overrun); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    logic [15:0] exp [4];
    exp = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    pulse(0, exp[0]);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy_collect got=%b want=1", bus.busy); end
    pulse(1, exp[1]);
    pulse(2, exp[2]);
    pulse(3, exp[3]);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_valid_at_entry got=%b want=0", bus.out_valid); end
    stream_capture(-1, 0, 20);
    total++; if (got_n !== 4) begin bad++; $display("FAIL single_word_count got=%0d want=4", got_n); end
    for (int i = 0; i < 4; i++) begin
      total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL single_word%0d got=%h want=%h", i, got[i], exp[i]); end
    end
    total++; if (first_valid_cyc !== 1) begin bad++; $display("FAIL single_first_valid got=%0d want=1", first_valid_cyc); end
    total++; if (last_xfer_cyc - first_valid_cyc !== 3) begin bad++; $display("FAIL single_back_to_back span got=%0d want=3", last_xfer_cyc - first_valid_cyc); end
    total++; if (fd_cnt !== 1 || fd_gap !== 1) begin bad++; $display("FAIL single_frame_done cnt=%0d gap=%0d want 1/1", fd_cnt, fd_gap); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_busy_after got=%b want=0", bus.busy); end
    @(negedge clk);
    total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL single_frame_done_width got=%b want=0", bus.frame_done); end
  endtask

  task automatic test_simultaneous();
    logic [15:0] exp [4];
    exp = '{16'hA000, 16'hA001, 16'hA002, 16'hA003};
    @(negedge clk);
    bus.neuron_valid = 4'hF;
    bus.neuron_out = {exp[3], exp[2], exp[1], exp[0]};
    stream_capture(-1, 0, 20);
    total++; if (got_n !== 4) begin bad++; $display("FAIL simul_word_count got=%0d want=4", got_n); end
    for (int i = 0; i < 4; i++) begin
      total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL simul_word%0d got=%h want=%h", i, got[i], exp[i]); end
    end
    total++; if (first_valid_cyc !== 3) begin bad++; $display("FAIL simul_first_valid got=%0d want=3", first_valid_cyc); end
    total++; if (busy_low !== 0) begin bad++; $display("FAIL simul_busy_low got=%0d want=0", busy_low); end
    total++; if (fd_cnt !== 1) begin bad++; $display("FAIL simul_frame_done got=%0d want=1", fd_cnt); end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp [4];
    exp = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    for (int i = 0; i < 4; i++) pulse(i, exp[i]);
    stream_capture(1, 3, 30);
    total++; if (got_n !== 4) begin bad++; $display("FAIL bp_word_count got=%0d want=4", got_n); end
    for (int i = 0; i < 4; i++) begin
      total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL bp_word%0d got=%h want=%h", i, got[i], exp[i]); end
    end
    total++; if (hold_cnt !== 4) begin bad++; $display("FAIL bp_hold_cycles got=%0d want=4", hold_cnt); end
    total++; if (hold_bad !== 0) begin bad++; $display("FAIL bp_hold_stable changes=%0d want=0", hold_bad); end
    total++; if (fd_cnt !== 1 || fd_gap !== 1) begin bad++; $display("FAIL bp_frame_done cnt=%0d gap=%0d want 1/1", fd_cnt, fd_gap); end
  endtask

  task automatic test_overwrite_overrun();
    logic [15:0] exp [4];
    exp = '{16'h0001, 16'h0002, 16'h0200, 16'h0004};
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear_before got=%b want=0", bus.overrun); end
    pulse(0, 16'h0001);
    pulse(1, 16'h0002);
    pulse(2, 16'h0100);
    pulse(2, 16'h0200);
    total++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL ovr_no_early_stream valid=%b busy=%b want 0/1", bus.out_valid, bus.busy); end
    pulse(3, 16'h0004);
    bus.neuron_valid = 4'b0010;
    bus.neuron_out[1*DW +: DW] = 16'hDEAD;
    stream_capture(-1, 0, 20);
    total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b want=1", bus.overrun); end
    total++; if (got_n !== 4) begin bad++; $display("FAIL ovr_word_count got=%0d want=4", got_n); end
    for (int i = 0; i < 4; i++) begin
      total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL ovr_word%0d got=%h want=%h", i, got[i], exp[i]); end
    end
    repeat (2) @(negedge clk);
    total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b want=1", bus.overrun); end
  endtask

  task automatic test_reset_mid_stream();
    logic [15:0] exp [4];
    int n;
    logic reached;
    exp = '{16'h0C01, 16'h0C02, 16'h0C03, 16'h0C04};
    n = 0; reached = 1'b0;
    @(negedge clk);
    bus.neuron_valid = 4'hF;
    bus.neuron_out = {16'h5553, 16'h5552, 16'h5551, 16'h5550};
    for (int c = 0; c < 20 && !reached; c++) begin
      @(negedge clk);
      bus.neuron_valid = '0;
      if (bus.out_valid) begin
        if (n == 2) reached = 1'b1;
        else n++;
      end
    end
    total++; if (reached !== 1'b1) begin bad++; $display("FAIL rst_mid_reach_index2 got=%b want=1", reached); end
    #2 rst = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b want=0", bus.busy); end
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL rst_mid_overrun got=%b want=0", bus.overrun); end
    total++; if (bus.out_data !== 16'h0000) begin bad++; $display("FAIL rst_mid_out_data got=%h want=0000", bus.out_data); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) pulse(i, exp[i]);
    stream_capture(-1, 0, 20);
    total++; if (got_n !== 4) begin bad++; $display("FAIL rst_fresh_word_count got=%0d want=4", got_n); end
    for (int i = 0; i < 4; i++) begin
      total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL rst_fresh_word%0d got=%h want=%h", i, got[i], exp[i]); end
    end
    total++; if (first_valid_cyc !== 1) begin bad++; $display("FAIL rst_fresh_first_valid got=%0d want=1", first_valid_cyc); end
    total++; if (fd_cnt !== 1) begin bad++; $display("FAIL rst_fresh_frame_done got=%0d want=1", fd_cnt); end
  endtask

  initial begin
    rst = 1'b0;
    bus.neuron_valid = '0;
    bus.neuron_out = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_single_frame();
    test_simultaneous();
    test_backpressure();
    test_overwrite_overrun();
    test_reset_mid_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
